iram_init_loader: RTL and testbench

- Initialisation master for the 512x9 instruction RAM init port: drives INITADDR/WENABLE/INITDATA.
- Consumes a byte stream (from a UART/SPI bridge) with valid/ready handshake, unpacks 9-bit instruction words, and writes them sequentially into the RAM.
- Validates length and checksum; holds the processor in reset until a good image has loaded.

---
 rtl/iram_init_loader.sv | 169 ++++++++++++++++
 tb/tb_iram_init_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iram_init_loader.sv
// Instruction RAM initialisation master: unpacks a byte stream into 9-bit
// words, writes them through the RAM init port and validates the image.
module iram_init_loader #(
    parameter int MAX_WORDS = 512,
    parameter int BASE_ADDR = 0
) (
    input  logic       RWCLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] SDATA,
    input  logic       SVALID,
    output logic       SREADY,
    output logic [8:0] INITADDR,
    output logic       WENABLE,
    output logic [8:0] INITDATA,
    output logic       CPU_HOLD,
    output logic       INITDONE,
    output logic       INITERR,
    output logic [1:0] ERRCODE
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_W_LO,
        S_W_HI, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [8:0]  BASE9 = 9'(BASE_ADDR);
    localparam logic [17:0] BASE18 = 18'(BASE_ADDR);
    localparam logic [17:0] MAX18 = 18'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [7:0]  acc, len_lo, lo_byte;
    logic [15:0] rem;
    logic [8:0]  waddr;

    logic        accept, start_go;
    logic [15:0] len_n;
    logic [7:0]  acc_sum;
    logic        len_bad, pad_bad, sum_ok;

    logic        sready_d, wr_d, err_set, done_set;
    logic [1:0]  errcode_d;

    assign accept   = SVALID & SREADY;
    assign len_n    = {SDATA, len_lo};
    assign acc_sum  = acc + SDATA;
    assign len_bad  = (len_n == 16'd0) ||
                      ((BASE18 + {2'b00, len_n}) > MAX18);
    assign pad_bad  = (SDATA[7:1] != 7'd0);
    assign sum_ok   = (acc_sum == 8'd0);
    assign start_go = START && ((state == S_IDLE) ||
                                (state == S_DONE) ||
                                (state == S_ERROR));

    // State register
    always_ff @(posedge RWCLK) begin
        if (!RESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; stream states advance only on a handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR:
                if (START) state_nxt = S_LEN_LO;
            S_LEN_LO:
                if (accept) state_nxt = S_LEN_HI;
            S_LEN_HI:
                if (accept) state_nxt = len_bad ? S_ERROR : S_W_LO;
            S_W_LO:
                if (accept) state_nxt = S_W_HI;
            S_W_HI:
                if (accept) begin
                    if (pad_bad)          state_nxt = S_ERROR;
                    else if (rem == 16'd1) state_nxt = S_CSUM;
                    else                  state_nxt = S_W_LO;
                end
            S_CSUM:
                if (accept) state_nxt = sum_ok ? S_DONE : S_ERROR;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        sready_d  = (state_nxt == S_LEN_LO) || (state_nxt == S_LEN_HI) ||
                    (state_nxt == S_W_LO)   || (state_nxt == S_W_HI)   ||
                    (state_nxt == S_CSUM);
        wr_d      = 1'b0;
        err_set   = 1'b0;
        done_set  = 1'b0;
        errcode_d = 2'd0;
        if (accept) begin
            unique case (state)
                S_LEN_HI:
                    if (len_bad) begin
                        err_set   = 1'b1;
                        errcode_d = 2'd1;
                    end
                S_W_HI:
                    if (pad_bad) begin
                        err_set   = 1'b1;
                        errcode_d = 2'd2;
                    end else begin
                        wr_d = 1'b1;
                    end
                S_CSUM:
                    if (sum_ok) begin
                        done_set = 1'b1;
                    end else begin
                        err_set   = 1'b1;
                        errcode_d = 2'd3;
                    end
                default: ;
            endcase
        end
    end

    // Datapath, RAM port and status registers
    always_ff @(posedge RWCLK) begin
        if (!RESET) begin
            SREADY   <= 1'b0;
            WENABLE  <= 1'b0;
            INITADDR <= 9'd0;
            INITDATA <= 9'd0;
            CPU_HOLD <= 1'b1;
            INITDONE <= 1'b0;
            INITERR  <= 1'b0;
            ERRCODE  <= 2'd0;
            acc      <= 8'd0;
            len_lo   <= 8'd0;
            lo_byte  <= 8'd0;
            rem      <= 16'd0;
            waddr    <= 9'd0;
        end else begin
            SREADY  <= sready_d;
            WENABLE <= wr_d;
            if (start_go) begin
                acc      <= 8'd0;
                INITDONE <= 1'b0;
                INITERR  <= 1'b0;
                ERRCODE  <= 2'd0;
                CPU_HOLD <= 1'b1;
                waddr    <= BASE9;
            end else if (accept) begin
                acc <= acc_sum;
            end
            if (accept && state == S_LEN_LO) len_lo <= SDATA;
            if (accept && state == S_LEN_HI) rem <= len_n;
            if (accept && state == S_W_LO)   lo_byte <= SDATA;
            if (wr_d) begin
                INITADDR <= waddr;
                INITDATA <= {SDATA[0], lo_byte};
                waddr    <= waddr + 9'd1;
                rem      <= rem - 16'd1;
            end
            if (err_set) begin
                INITERR <= 1'b1;
                ERRCODE <= errcode_d;
            end
            if (done_set) begin
                INITDONE <= 1'b1;
                CPU_HOLD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iram_init_loader.sv
// Bench for iram_init_loader: two instances (base 0 and base 500),
// scoreboard of expected RAM writes checked by a negedge monitor.
module tb_iram_init_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] sdata = 8'd0;
    logic       svalid = 1'b0;

    logic       sready0, wen0, hold0, done0, err0;
    logic [8:0] addr0, data0;
    logic [1:0] code0;
    logic       sready1, wen1, hold1, done1, err1;
    logic [8:0] addr1, data1;
    logic [1:0] code1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nwr0 = 0, t_first = 0, t_last = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [8:0]  wq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iram_init_loader #(.MAX_WORDS(512), .BASE_ADDR(0)) u0 (
        .RWCLK(clk), .RESET(rst), .START(start0),
        .SDATA(sdata), .SVALID(svalid), .SREADY(sready0),
        .INITADDR(addr0), .WENABLE(wen0), .INITDATA(data0),
        .CPU_HOLD(hold0), .INITDONE(done0), .INITERR(err0),
        .ERRCODE(code0)
    );

    iram_init_loader #(.MAX_WORDS(512), .BASE_ADDR(500)) u1 (
        .RWCLK(clk), .RESET(rst), .START(start1),
        .SDATA(sdata), .SVALID(svalid), .SREADY(sready1),
        .INITADDR(addr1), .WENABLE(wen1), .INITDATA(data1),
        .CPU_HOLD(hold1), .INITDONE(done1), .INITERR(err1),
        .ERRCODE(code1)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (wen0) begin
            checks++;
            if (nwr0 == 0) t_first = cyc;
            t_last = cyc;
            nwr0++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected: got addr %0d data 0x%0h, expected none",
                         addr0, data0);
            end else begin
                logic [17:0] e;
                e = q0.pop_front();
                if ({addr0, data0} != e) begin
                    errors++;
                    $display("FAIL wr0: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                             addr0, data0, e[17:9], e[8:0]);
                end
            end
        end
        if (wen1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected: got addr %0d data 0x%0h, expected none",
                         addr1, data1);
            end else begin
                logic [17:0] e;
                e = q1.pop_front();
                if ({addr1, data1} != e) begin
                    errors++;
                    $display("FAIL wr1: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                             addr1, data1, e[17:9], e[8:0]);
                end
            end
        end
    end

    task automatic go(input bit which);
        @(negedge clk);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        sdata  = 8'hFF;
        svalid = 1'b1;
        check("sready_idle_start", which ? sready1 : sready0, 0);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        svalid = 1'b0;
    endtask

    task automatic send(input bit which, input logic [7:0] b, input bit gaps);
        int n;
        @(negedge clk);
        if (gaps && $urandom_range(0, 2) == 0) begin
            svalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        sdata  = b;
        svalid = 1'b1;
        n = 0;
        while (!(which ? sready1 : sready0)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                errors++;
                $display("FAIL handshake_timeout: got no SREADY, expected SREADY");
                break;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        svalid = 1'b0;
    endtask

    // Sends a frame built from wq; pushes expected writes as it goes
    task automatic frame(input bit which, input int n, input int bad_pad,
                         input int cadj, input bit gaps, input int nwords);
        logic [7:0] s, lo, hi;
        int base;
        base = which ? 500 : 0;
        s = 8'd0;
        lo = n[7:0];
        hi = n[15:8];
        send(which, lo, gaps); s += lo;
        send(which, hi, gaps); s += hi;
        if (n == 0 || base + n > 512) begin
            idle();
            return;
        end
        for (int k = 0; k < nwords; k++) begin
            lo = wq[k][7:0];
            hi = (k == bad_pad) ? 8'h02 : {7'd0, wq[k][8]};
            send(which, lo, gaps); s += lo;
            if (k != bad_pad) begin
                logic [8:0] a;
                a = 9'(base + k);
                if (which) q1.push_back({a, wq[k]});
                else       q0.push_back({a, wq[k]});
            end
            send(which, hi, gaps); s += hi;
            if (k == bad_pad) begin
                idle();
                return;
            end
        end
        if (nwords < n) begin
            idle();
            return;
        end
        lo = 8'(8'd0 - s + 8'(cadj));
        send(which, lo, gaps);
        idle();
    endtask

    task automatic status(input string name, input bit which, input int done,
                          input int err, input int code, input int hold);
        repeat (2) @(negedge clk);
        check({name, "_done"}, which ? done1 : done0, done);
        check({name, "_err"},  which ? err1  : err0,  err);
        check({name, "_code"}, which ? code1 : code0, code);
        check({name, "_hold"}, which ? hold1 : hold0, hold);
        check({name, "_sready"}, which ? sready1 : sready0, 0);
        check({name, "_q_empty"}, which ? q1.size() : q0.size(), 0);
    endtask

    task automatic fill(input int n, input int mul, input int add);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(9'((k * mul + add) % 512));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sready", sready0, 0);
        check("rst_wen",    wen0,    0);
        check("rst_addr",   addr0,   0);
        check("rst_data",   data0,   0);
        check("rst_hold",   hold0,   1);
        check("rst_done",   done0,   0);
        check("rst_err",    err0,    0);
        check("rst_code",   code0,   0);
        rst = 1'b1;
        @(negedge clk);

        // Basic load: words 0x1A5, 0x003
        wq.delete();
        wq.push_back(9'h1A5);
        wq.push_back(9'h003);
        go(0);
        frame(0, 2, -1, 0, 0, 2);
        status("basic", 0, 1, 0, 0, 0);

        // Full image, back-to-back
        fill(512, 1, 0);
        nwr0 = 0;
        go(0);
        frame(0, 512, -1, 0, 0, 512);
        status("full", 0, 1, 0, 0, 0);
        check("full_nwr", nwr0, 512);
        check("full_span", t_last - t_first, 1022);

        // Length errors
        go(0);
        frame(0, 0, -1, 0, 0, 0);
        status("len0", 0, 0, 1, 1, 1);
        go(0);
        frame(0, 513, -1, 0, 0, 0);
        status("len513", 0, 0, 1, 1, 1);

        // Pad bits in word 0
        fill(4, 7, 3);
        go(0);
        frame(0, 4, 0, 0, 0, 4);
        status("pad", 0, 0, 1, 2, 1);

        // Bad checksum: all writes happen, then error
        fill(3, 11, 200);
        go(0);
        frame(0, 3, -1, 1, 0, 3);
        status("csum", 0, 0, 1, 3, 1);

        // Stalled basic load
        wq.delete();
        wq.push_back(9'h1A5);
        wq.push_back(9'h003);
        go(0);
        frame(0, 2, -1, 0, 1, 2);
        status("stall", 0, 1, 0, 0, 0);

        // Reset after third word
        fill(5, 37, 5);
        go(0);
        frame(0, 5, -1, 0, 0, 3);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sready", sready0, 0);
        check("mid_rst_wen",    wen0,    0);
        check("mid_rst_addr",   addr0,   0);
        check("mid_rst_data",   data0,   0);
        check("mid_rst_hold",   hold0,   1);
        check("mid_rst_err",    err0,    0);
        check("mid_rst_q",      q0.size(), 0);
        rst = 1'b1;
        fill(8, 93, 17);
        go(0);
        frame(0, 8, -1, 0, 1, 8);
        status("restart", 0, 1, 0, 0, 0);

        // Base 500
        fill(12, 41, 9);
        go(1);
        frame(1, 12, -1, 0, 0, 12);
        status("base_n12", 1, 1, 0, 0, 0);
        fill(13, 1, 0);
        go(1);
        frame(1, 13, -1, 0, 0, 0);
        status("base_n13", 1, 0, 1, 1, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
